// File: rtl/maj_chain_sequencer.sv
// Time-multiplexed majority-chain classifier: one shared MAJ3 unit walks a
// small writable program of majority nodes, one node per clock, and returns
// the last node's value as the class bit.
module maj_chain_sequencer #(
  parameter int unsigned NUM_NODES = 5,
  parameter int unsigned OP_W      = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [3*OP_W-1:0]   cfg_data,
  output logic                cfg_busy
);

  localparam int unsigned CFG_W     = 3 * OP_W;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned MAX_NODES = 8;
  localparam int unsigned SEL_W     = OP_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic                   w_accept;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_out;
  logic [6:0]             r_x;
  logic [IDX_W-1:0]       r_idx;
  logic [MAX_NODES-1:0]   r_node;
  logic [CFG_W-1:0]       r_prog [NUM_NODES];
  logic [CFG_W-1:0]       w_cur;
  logic [2:0]             w_val;
  logic                   w_maj;

  // Power-on / reset contents of each program slot.
  function automatic logic [CFG_W-1:0] dflt_prog(input int unsigned k);
    case (k)
      0:       return {OP_W'(3),  OP_W'(2), OP_W'(1)};
      1:       return {OP_W'(8),  OP_W'(4), OP_W'(2)};
      2:       return {OP_W'(9),  OP_W'(6), OP_W'(1)};
      3:       return {OP_W'(10), OP_W'(5), OP_W'(4)};
      4:       return {OP_W'(11), OP_W'(8), OP_W'(0)};
      default: return {OP_W'(7),  OP_W'(7), OP_W'(7)};
    endcase
  endfunction

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign cfg_busy  = r_busy;
  assign out       = r_out;

  // Next-state logic for the IDLE -> EVAL -> DONE sequence.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept   = 1'b1;
          w_state_nx = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_idx == LAST_IDX) w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register plus handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == S_IDLE);
      r_out_valid <= (w_state_nx == S_DONE);
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  // Operand fetch and the shared MAJ3; nodes at or beyond idx read as 0.
  always_comb begin
    w_cur = r_prog[r_idx];
    w_val = '0;
    for (int j = 0; j < 3; j++) begin : g_opnd
      logic [OP_W-1:0]  w_op;
      logic [SEL_W-1:0] w_sel;
      logic             w_bit;
      w_op  = w_cur[j*OP_W +: OP_W];
      w_sel = w_op[SEL_W-1:0];
      w_bit = 1'b0;
      if (w_sel < SEL_W'(7)) begin
        w_bit = r_x[w_sel[2:0]];
      end else if (w_sel[SEL_W-1] && (w_sel[2:0] < r_idx)) begin
        w_bit = r_node[w_sel[2:0]];
      end
      w_val[j] = w_bit ^ w_op[OP_W-1];
    end
    w_maj = (w_val[0] & w_val[1]) | (w_val[0] & w_val[2]) | (w_val[1] & w_val[2]);
  end

  // Program store, sample capture, node evaluation and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_idx  <= '0;
      r_node <= '0;
      r_out  <= 1'b0;
      for (int k = 0; k < NUM_NODES; k++) r_prog[k] <= dflt_prog(k);
    end else begin
      if ((r_state == S_IDLE) && cfg_we && (4'(cfg_addr) < 4'(NUM_NODES))) begin
        r_prog[cfg_addr] <= cfg_data;
      end
      if (w_accept) begin
        r_x    <= x;
        r_idx  <= '0;
        r_node <= '0;
      end else if (r_state == S_EVAL) begin
        r_node[r_idx] <= w_maj;
        if (r_idx == LAST_IDX) begin
          r_out <= w_maj;
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/maj_chain_sequencer.md
Name: maj_chain_sequencer

Overview:
- Time-multiplexed evaluator for 7-input majority-chain classifiers.
- Owns a single shared MAJ3 unit and a small writable program of NUM_NODES majority nodes.
- Evaluates one node per clock and returns the last node's value as the class bit.
- Sits between a sample source (valid/ready) and a result sink (valid/ready); a host loads the program through a config write port.

Parameters:
- NUM_NODES, 5, number of majority nodes in the program (1..8); node NUM_NODES-1 is the output node.
- OP_W, 5, operand field width: bit4 = invert, bits3:0 = select.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample x is valid.
- in_ready  out  1  block can accept a sample.
- x  in  7  sample inputs x0..x6 (bit i = x_i).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out  out  1  class bit (value of the last node).
- cfg_we  in  1  program write strobe.
- cfg_addr  in  3  node index to write.
- cfg_data  in  15  operands: a = [4:0], b = [9:5], c = [14:10].
- cfg_busy  out  1  high when not IDLE; writes are ignored while high.

Behaviour:
- Operand select encoding:
  - 0..6 = x_i (captured copy).
  - 7 = constant 0.
  - 8+k = result of node k.
  - Selects 8+NUM_NODES..15 read 0.
  - Invert bit XORs the selected value.
- Node result = MAJ(a, b, c) = ab | ac | bc.
- Node result registers are cleared to 0 at sample accept. A select of a node with k >= the current index reads 0; this is legal, not an error.
- States:
  - IDLE: in_ready=1.
    - in_valid && in_ready: capture x, clear node registers, idx=0, go to EVAL.
  - EVAL: each cycle evaluate node idx through the one MAJ3 unit, write result[idx], idx++.
    - After writing idx = NUM_NODES-1: out <= result, go to DONE.
  - DONE: out_valid=1, out held stable.
    - out_ready: go to IDLE (out_valid drops next cycle; out holds its value).
- Latency: handshake in cycle 0 -> out_valid high from cycle NUM_NODES+1. Throughput is one sample per NUM_NODES+2 cycles minimum.
- in_ready=0 in EVAL and DONE, so there is never an overlap between an accept and a pending result. in_valid in DONE is not accepted until the cycle after IDLE is re-entered.
- x is sampled only on accept; changes on x during EVAL have no effect.
- cfg_we is honoured only in IDLE.
  - Written on that clock edge; used by the next sample.
  - A write and an accept in the same IDLE cycle: the write takes effect first, so the accepted sample uses the new program.
  - cfg_addr >= NUM_NODES is ignored.
- Reset (any state, including mid-EVAL or DONE):
  - state=IDLE; in_ready=1; out_valid=0; out=0; cfg_busy=0; idx=0; node registers 0.
  - Program restored to the default below.
- Default program:
  - n0=MAJ(x1,x2,x3)
  - n1=MAJ(x2,x4,n0)
  - n2=MAJ(x1,x6,n1)
  - n3=MAJ(x4,x5,n2)
  - n4=MAJ(x0,n0,n3)
  - Unused nodes (NUM_NODES>5): MAJ(c0,c0,c0) = 0.

Test Plan:
- Reset, default program, x=7'b0000111 (x0=x1=x2=1): n0..n4 = 1,1,1,0,1 -> out_valid in cycle 6 after accept, out=1.
- Default program, x=7'b0000001 -> out=0. Hold out_ready=0 for 4 cycles: out_valid and out stay stable, in_ready stays 0.
- In IDLE write addr4 = {a=5'b10111, b=5'b10111, c=5'd0} (~c0, ~c0, x0), then x=0 -> out=1. Reset -> default restored, x=0 -> out=0.
- cfg_we during EVAL with addr0 = all ~c0: ignored, current and next sample use the old program. cfg_addr=6 with NUM_NODES=5: ignored.
- Assert rst_n=0 in cycle 3 of EVAL: next cycle in_ready=1, out_valid=0. A fresh sample then completes with correct latency (6 cycles).
- Forward reference: node0 = MAJ(n2, ~c0, x0), x0=1, other nodes default -> n0 reads n2 as 0, n0 = MAJ(0,1,1) = 1. Check out against the golden model.
